// File: rtl/muldiv_seq_div_if.sv
// rtl/muldiv_seq_div_if.sv - request/response handshake bundle between EX issue logic and the iterative divider
interface muldiv_seq_div_if #(
    parameter int XLEN = 32
);
    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic [2:0]      funct3_i;
    logic            flush_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] result_o;
    logic            busy_o;

    modport master (
        output req_valid_i, op_a_i, op_b_i, funct3_i, flush_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, result_o, busy_o
    );

    modport slave (
        input  req_valid_i, op_a_i, op_b_i, funct3_i, flush_i, resp_ready_i,
        output req_ready_o, resp_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/muldiv_seq_div.sv
// rtl/muldiv_seq_div.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, XLEN cycles per divide
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module muldiv_seq_div #(
    parameter int XLEN = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    muldiv_seq_div_if.slave    bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            busy_q, busy_d;

    logic            is_signed;
    logic            is_rem_req;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            b_zero;
    logic            ovf;
    logic            accept;

    // funct3[0] selects unsigned, funct3[1] selects remainder
    assign is_signed  = ~bus.funct3_i[0];
    assign is_rem_req = bus.funct3_i[1];
    assign sign_a     = is_signed & bus.op_a_i[XLEN-1];
    assign sign_b     = is_signed & bus.op_b_i[XLEN-1];
    assign abs_a      = sign_a ? (~bus.op_a_i + 1'b1) : bus.op_a_i;
    assign abs_b      = sign_b ? (~bus.op_b_i + 1'b1) : bus.op_b_i;
    assign b_zero     = (bus.op_b_i == '0);
    assign ovf        = is_signed & (bus.op_a_i == INT_MIN) & (&bus.op_b_i);
    assign accept     = bus.req_valid_i & req_ready_q & ~bus.flush_i;

    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quot_nx;
    logic [XLEN-1:0] rem_fin;
    logic [XLEN-1:0] quot_fin;

    // One restoring step: shift {rem, quot} left, trial-subtract the divisor
    assign rem_sh   = {rem_q, quot_q[XLEN-1]};
    assign diff     = rem_sh - {1'b0, div_q};
    assign rem_nx   = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_nx  = {quot_q[XLEN-2:0], ~diff[XLEN]};
    assign rem_fin  = neg_rem_q  ? (~rem_nx + 1'b1)  : rem_nx;
    assign quot_fin = neg_quot_q ? (~quot_nx + 1'b1) : quot_nx;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        div_d      = div_q;
        result_d   = result_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        is_rem_d   = is_rem_q;

        if (bus.flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_rem_d   = is_rem_req;
                        neg_quot_d = sign_a ^ sign_b;
                        neg_rem_d  = sign_a;
                        cnt_d      = '0;
                        if (!bus.funct3_i[2]) begin
                            result_d = '0;
                            state_d  = DONE;
                        end else if (b_zero) begin
                            result_d = is_rem_req ? bus.op_a_i : '1;
                            state_d  = DONE;
                        end else if (ovf) begin
                            result_d = is_rem_req ? '0 : INT_MIN;
                            state_d  = DONE;
`ifdef DIV_EARLY_OUT_EN
                        end else if (abs_a < abs_b) begin
                            result_d = is_rem_req ? bus.op_a_i : '0;
                            state_d  = DONE;
`endif
                        end else begin
                            rem_d   = '0;
                            quot_d  = abs_a;
                            div_d   = abs_b;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    rem_d  = rem_nx;
                    quot_d = quot_nx;
                    if (cnt_q == CNT_LAST) begin
                        result_d = is_rem_q ? rem_fin : quot_fin;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.resp_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            div_q        <= '0;
            result_q     <= '0;
            neg_quot_q   <= 1'b0;
            neg_rem_q    <= 1'b0;
            is_rem_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            div_q        <= div_d;
            result_q     <= result_d;
            neg_quot_q   <= neg_quot_d;
            neg_rem_q    <= neg_rem_d;
            is_rem_q     <= is_rem_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready_o  = req_ready_q;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.result_o     = result_q;
    assign bus.busy_o       = busy_q;
endmodule

// File: tb/tb_muldiv_seq_div.sv
// tb/tb_muldiv_seq_div.sv - directed self-checking bench for muldiv_seq_div
module tb_muldiv_seq_div;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_seq_div_if #(.XLEN(32)) bus ();

    muldiv_seq_div #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input bit retire);
        int   cyc;
        logic got_v;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) break;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready_o), 32'd1);
        bus.op_a_i      = a;
        bus.op_b_i      = b;
        bus.funct3_i    = f3;
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.op_a_i      = ~a;
        bus.op_b_i      = ~b;
        bus.funct3_i    = ~f3;
        cyc   = 1;
        got_v = 1'b0;
        while (cyc < 80 && !got_v) begin
            @(negedge clk);
            if (bus.resp_valid_o) got_v = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_res"}, bus.result_o, exp_res);
        if (retire) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_retired"}, 32'(bus.resp_valid_o), 32'd0);
            chk({tag, "_idle_ready"}, 32'(bus.req_ready_o), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        bus.req_valid_i  = 1'b0;
        bus.op_a_i       = '0;
        bus.op_b_i       = '0;
        bus.funct3_i     = '0;
        bus.flush_i      = 1'b0;
        bus.resp_ready_i = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready_o),  32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("rst_result",     bus.result_o,          32'd0);
        chk("rst_busy",       32'(bus.busy_o),       32'd0);
        rst_n = 1'b1;

        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b1);
        run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1);
        run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1);
        run_op("div_7_m2",   3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b1);
        run_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b1);
        run_op("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b1);
        run_op("div_5_0",    3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
        run_op("remu_5_0",   3'b111, 32'd5, 32'd0, 32'd5, 1, 1'b1);
        run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
        run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);
        run_op("illegal_f3", 3'b001, 32'd100, 32'd7, 32'd0, 1, 1'b1);
        run_op("divu_3_10",  3'b101, 32'd3, 32'd10, 32'd0, EO_LAT, 1'b1);
        run_op("remu_3_10",  3'b111, 32'd3, 32'd10, 32'd3, EO_LAT, 1'b1);

        // Backpressure: result held while the core stalls
        bus.resp_ready_i = 1'b0;
        run_op("bp_divu", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid",  32'(bus.resp_valid_o), 32'd1);
            chk("bp_result", bus.result_o,          32'd14);
            chk("bp_ready",  32'(bus.req_ready_o),  32'd0);
        end
        bus.resp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.req_ready_o),  32'd1);
        chk("bp_release_valid", 32'(bus.resp_valid_o), 32'd0);

        // Flush at CALC cycle 10
        bus.op_a_i      = 32'd1000;
        bus.op_b_i      = 32'd3;
        bus.funct3_i    = 3'b101;
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("fl_busy_before", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        chk("fl_valid", 32'(bus.resp_valid_o), 32'd0);
        chk("fl_busy",  32'(bus.busy_o),       32'd0);
        chk("fl_ready", 32'(bus.req_ready_o),  32'd1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid_o) seen = 1'b1;
        end
        chk("fl_no_resp", 32'(seen), 32'd0);
        run_op("fl_divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 33, 1'b1);

        // Request coincident with flush must be dropped
        @(negedge clk);
        bus.op_a_i      = 32'd5;
        bus.op_b_i      = 32'd0;
        bus.funct3_i    = 3'b100;
        bus.req_valid_i = 1'b1;
        bus.flush_i     = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
        @(negedge clk);
        chk("flreq_busy",   32'(bus.busy_o),       32'd0);
        chk("flreq_valid",  32'(bus.resp_valid_o), 32'd0);
        chk("flreq_result", bus.result_o,          32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq_div.md
Name: muldiv_seq_div

Overview:
- Multi-cycle iterative (radix-2, restoring) divider for RV32M DIV/DIVU/REM/REMU.
- Acts as the responder to the EX-stage issue logic. The core raises a request with operands and funct3, holds its pipeline, and accepts the response through a valid/ready handshake.
- Replaces the single-cycle combinational divide path in timing-critical builds. MUL* operations stay on the combinational multiplier.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  divide request valid
- req_ready_o  out  1  unit can accept a request (high only in IDLE)
- op_a_i  in  XLEN  dividend (rs1)
- op_b_i  in  XLEN  divisor (rs2)
- funct3_i  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- flush_i  in  1  pipeline flush; abandons any operation in flight
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  core accepts result
- result_o  out  XLEN  quotient or remainder
- busy_o  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_ni.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; result_o=0; busy_o=0; all internal registers 0.
- Request acceptance:
  - A request is accepted in the cycle where req_valid_i & req_ready_o.
  - op_a_i, op_b_i and funct3_i are registered on acceptance. Later changes to these inputs are ignored.
  - funct3_i[2]=0 on an accepted request is illegal. The unit returns result 0 after one cycle, following the special-case path.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> CALC on accept, when no special case applies.
  - IDLE -> DONE on accept, when a special case applies.
  - CALC -> DONE when the iteration counter reaches XLEN-1.
  - DONE -> IDLE on resp_ready_i.
- Latency:
  - Normal path: accept in cycle 0, XLEN CALC cycles (1..XLEN), resp_valid_o high from cycle XLEN+1.
  - Special cases: resp_valid_o high from cycle 1.
- Signed handling:
  - On accept, signed ops (DIV/REM) store |op_a| and |op_b| and record both sign bits.
  - The quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Negation happens in the CALC->DONE transition, so result_o is registered and stable during DONE.
- Iteration:
  - Each cycle, the {rem, quot} pair shifts left by one.
  - Trial subtraction uses an XLEN+1-bit difference.
  - If the difference is non-negative, rem takes the difference and quot LSB is set to 1.
  - Counter width is $clog2(XLEN); it does not wrap past XLEN-1.
- Special cases (evaluated on the raw operands at accept):
  - Divide by 0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): DIV -> 0x80000000; REM -> 0.
- Response handshake:
  - resp_valid_o stays high and result_o is held until resp_ready_i.
  - A new request is not accepted in the same cycle the response retires. req_ready_o rises the following cycle, in IDLE.
- flush_i:
  - Has priority over every other event.
  - Any state goes to IDLE next cycle, with resp_valid_o=0 and the counter cleared.
  - A request presented in the same cycle as flush_i is not accepted.
- result_o holds its last value in IDLE. It is only updated on entry to DONE.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: on accept, if |op_a| < |op_b| (magnitude compare after sign handling) and no special case applies, go straight to DONE with quotient 0 and remainder = op_a. Latency is 1.
- Undefined: no early-out; such operands take the full XLEN-cycle path with identical results.

Test Plan:
- DIVU 100/7, resp_ready_i held 1 -> resp_valid_o in cycle 33, result_o=14; REMU same operands -> 2.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF (-1). DIV 7/-2 -> 0xFFFFFFFD; REM -> 1.
- Special cases, each with resp_valid_o in cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Backpressure: hold resp_ready_i=0 for 10 cycles after DONE -> resp_valid_o and result_o stable, req_ready_o=0. Raise resp_ready_i -> IDLE next cycle, req_ready_o=1.
- flush_i asserted at CALC cycle 10 -> IDLE next cycle, no resp_valid_o. Follow-up DIVU 9/3 -> 3 with full latency.
- With DIV_EARLY_OUT_EN: DIVU 3/10 -> resp_valid_o in cycle 1, result_o=0; REMU 3/10 -> 3. Without the macro, the same results arrive in cycle 33.
